rv2t_instruction_fetch: RTL

RV2T_INSTRUCTION_FETCH -- requirements
Module: RV2T_instruction_fetch

---
 rtl/rv2t_instruction_fetch_pkg.sv | 28 ++
 rtl/rv2t_instruction_fetch_if.sv | 32 +++
 rtl/rv2t_instruction_fetch.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rv2t_instruction_fetch_pkg.sv
// rtl/rv2t_instruction_fetch_pkg.sv - shared widths, FSM encoding and PC helpers for instruction fetch
//
// Purpose: common definitions for the fetch unit and its memory interface.
//   XLEN          instruction word width
//   PC_BITWIDTH   program counter / address width
//   PC_INCREMENT  sequential fetch stride
//   fetch_state_t fetch FSM state encoding
//   word_align    clears the byte-offset bits of an address

package rv2t_instruction_fetch_pkg;

    localparam int XLEN        = 32;
    localparam int PC_BITWIDTH = 32;

    localparam logic [PC_BITWIDTH-1:0] PC_INCREMENT = PC_BITWIDTH'(4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    function automatic logic [PC_BITWIDTH-1:0] word_align(input logic [PC_BITWIDTH-1:0] addr);
        return {addr[PC_BITWIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv2t_instruction_fetch_if.sv
// rtl/rv2t_instruction_fetch_if.sv - instruction memory read port between fetch unit and memory
//
// Purpose: groups the instruction-memory read handshake.
//   mem_read_en    request, one cycle per read (fetch -> memory)
//   mem_read_addr  read address                (fetch -> memory)
//   mem_read_ack   read data valid this cycle  (memory -> fetch)
//   mem_read_data  instruction word            (memory -> fetch)
// Modports: master = fetch unit, slave = instruction memory.

interface rv2t_instruction_fetch_if;
    import rv2t_instruction_fetch_pkg::*;

    logic                   mem_read_en;
    logic [PC_BITWIDTH-1:0] mem_read_addr;
    logic                   mem_read_ack;
    logic [XLEN-1:0]        mem_read_data;

    modport master (
        output mem_read_en,
        output mem_read_addr,
        input  mem_read_ack,
        input  mem_read_data
    );

    modport slave (
        input  mem_read_en,
        input  mem_read_addr,
        output mem_read_ack,
        output mem_read_data
    );

endinterface

// File: rtl/rv2t_instruction_fetch.sv
// rtl/rv2t_instruction_fetch.sv - single-request instruction fetch FSM with jump redirect and discard
//
// Purpose: fetches one instruction at a time from instruction memory and
// hands it to decode; supports sequential advance, jump redirect (including
// redirect while a read is outstanding) and synchronous/asynchronous reset.
//
// Ports:
//   clk, reset_n (async, active-low), sync_reset (sync, active-high)
//   start / start_addr          begin fetching at start_addr (IDLE only)
//   fetch_enable                advance to PC + 4 from HOLD
//   jump_active / jump_addr     redirect pulse from execute
//   mem                         instruction memory read port (master)
//   enable_out, IR_out, PC_out  one-cycle delivery to decode
//   exception_instr_misaligned, exception_PC  misaligned-PC report
//
// Build option: RV2T_FETCH_MISALIGN_CHECK_EN enables the misaligned-PC
// exception; without it the read address is word-aligned and the exception
// outputs are tied low.

module rv2t_instruction_fetch
    import rv2t_instruction_fetch_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sync_reset,
    input  logic                    start,
    input  logic [PC_BITWIDTH-1:0]  start_addr,
    input  logic                    fetch_enable,
    input  logic                    jump_active,
    input  logic [PC_BITWIDTH-1:0]  jump_addr,
    rv2t_instruction_fetch_if.master mem,
    output logic                    enable_out,
    output logic [XLEN-1:0]         IR_out,
    output logic [PC_BITWIDTH-1:0]  PC_out,
    output logic                    exception_instr_misaligned,
    output logic [PC_BITWIDTH-1:0]  exception_PC
);

    fetch_state_t           state_q, state_d;
    logic [PC_BITWIDTH-1:0] pc_q, pc_d;
    logic [PC_BITWIDTH-1:0] target_q, target_d;
    logic                   discard_q, discard_d;
    logic [XLEN-1:0]        ir_d;
    logic [PC_BITWIDTH-1:0] pc_out_d;
    logic                   enable_d;
    logic                   mem_en;
    logic                   misaligned;

`ifdef RV2T_FETCH_MISALIGN_CHECK_EN
    assign misaligned        = (pc_q[1:0] != 2'b00);
    assign mem.mem_read_addr = pc_q;
`else
    assign misaligned        = 1'b0;
    assign mem.mem_read_addr = word_align(pc_q);
`endif

    assign mem.mem_read_en = mem_en;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        target_d  = target_q;
        discard_d = discard_q;
        ir_d      = IR_out;
        pc_out_d  = PC_out;
        enable_d  = 1'b0;
        mem_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = start_addr;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (misaligned) begin
                    // No request goes out, so there is nothing to discard later.
                    state_d = ST_IDLE;
                end else begin
                    mem_en  = 1'b1;
                    state_d = ST_WAIT;
                    if (jump_active) begin
                        target_d  = jump_addr;
                        discard_d = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                if (mem.mem_read_ack) begin
                    discard_d = 1'b0;
                    if (jump_active) begin
                        // Redirect arriving with the ack: the ack is the stale read.
                        pc_d    = jump_addr;
                        state_d = ST_REQ;
                    end else if (discard_q) begin
                        pc_d    = target_q;
                        state_d = ST_REQ;
                    end else begin
                        ir_d     = mem.mem_read_data;
                        pc_out_d = pc_q;
                        enable_d = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end else if (jump_active) begin
                    // Later jumps overwrite the pending target.
                    target_d  = jump_addr;
                    discard_d = 1'b1;
                end
            end

            ST_HOLD: begin
                if (jump_active) begin
                    pc_d    = jump_addr;
                    state_d = ST_REQ;
                end else if (fetch_enable) begin
                    pc_d    = pc_q + PC_INCREMENT;
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            target_q   <= '0;
            discard_q  <= 1'b0;
            IR_out     <= '0;
            PC_out     <= '0;
            enable_out <= 1'b0;
        end else if (sync_reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            target_q   <= '0;
            discard_q  <= 1'b0;
            IR_out     <= '0;
            PC_out     <= '0;
            enable_out <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            discard_q  <= discard_d;
            IR_out     <= ir_d;
            PC_out     <= pc_out_d;
            enable_out <= enable_d;
        end
    end

`ifdef RV2T_FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exception_instr_misaligned <= 1'b0;
            exception_PC               <= '0;
        end else if (sync_reset) begin
            exception_instr_misaligned <= 1'b0;
            exception_PC               <= '0;
        end else begin
            // REQ is left immediately on a misaligned PC, so this is a single pulse.
            exception_instr_misaligned <= (state_q == ST_REQ) && misaligned;
            if ((state_q == ST_REQ) && misaligned) begin
                exception_PC <= pc_q;
            end
        end
    end
`else
    assign exception_instr_misaligned = 1'b0;
    assign exception_PC               = '0;
`endif

endmodule
